count_date: RTL and testbench



---
 rtl/clock_pkg.sv | 45 ++++
 rtl/month_len.sv | 26 ++
 rtl/count_date.sv | 107 ++++++++++
 tb/tb_count_date.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the calendar counters: adjust selectors, BCD month codes
// and two-digit BCD increment/decrement helpers.
package clock_pkg;

   typedef logic [7:0] bcd2_t;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_DAY  = 2'b01;
   localparam logic [1:0] SEL_MON  = 2'b10;

   localparam bcd2_t MON_JAN = 8'h01;
   localparam bcd2_t MON_FEB = 8'h02;
   localparam bcd2_t MON_MAR = 8'h03;
   localparam bcd2_t MON_APR = 8'h04;
   localparam bcd2_t MON_MAY = 8'h05;
   localparam bcd2_t MON_JUN = 8'h06;
   localparam bcd2_t MON_JUL = 8'h07;
   localparam bcd2_t MON_AUG = 8'h08;
   localparam bcd2_t MON_SEP = 8'h09;
   localparam bcd2_t MON_OCT = 8'h10;
   localparam bcd2_t MON_NOV = 8'h11;
   localparam bcd2_t MON_DEC = 8'h12;

   localparam bcd2_t DAY_FIRST = 8'h01;

   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_CARRY,
      ACT_DAY_UP,
      ACT_DAY_DN,
      ACT_MON_UP,
      ACT_MON_DN
   } act_e;

   function automatic bcd2_t bcd_inc(input bcd2_t v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic bcd2_t bcd_dec(input bcd2_t v);
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                return {v[7:4], v[3:0] - 4'd1};
   endfunction

endpackage

// File: rtl/month_len.sv
// Last day of a BCD month as two BCD digits; February depends on leap_year.
module month_len
   import clock_pkg::*;
(
   input  logic [3:0] mon_ten,
   input  logic [3:0] mon_unit,
   input  logic       leap_year,
   output logic [3:0] last_ten,
   output logic [3:0] last_unit
);

   bcd2_t last;

   always_comb begin
      last = 8'h31;
      case ({mon_ten, mon_unit})
         MON_FEB:                           last = leap_year ? 8'h29 : 8'h28;
         MON_APR, MON_JUN, MON_SEP, MON_NOV: last = 8'h30;
         default:                           last = 8'h31;
      endcase
   end

   assign last_ten  = last[7:4];
   assign last_unit = last[3:0];

endmodule

// File: rtl/count_date.sv
// Day-of-month and month BCD counter: end-of-day carry, manual up/down adjust,
// and clamping of the day whenever it exceeds the month length.
module count_date
   import clock_pkg::*;
#(
   parameter int DIG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_day,
   input  logic             leap_year,
   input  logic             up,
   input  logic             down,
   input  logic [1:0]       sel,
   output logic [DIG_W-1:0] day_unit,
   output logic [DIG_W-1:0] day_ten,
   output logic [DIG_W-1:0] mon_unit,
   output logic [DIG_W-1:0] mon_ten,
   output logic             en_yr
);

   logic [3:0] day_unit_q, day_unit_d;
   logic [3:0] day_ten_q, day_ten_d;
   logic [3:0] mon_unit_q, mon_unit_d;
   logic [3:0] mon_ten_q, mon_ten_d;

   bcd2_t day, mon, mon_adj, last, day_n, mon_n;
   logic [3:0] last_ten, last_unit;
   logic at_last;
   act_e act;

   assign day = {day_ten_q, day_unit_q};
   assign mon = {mon_ten_q, mon_unit_q};

   always_comb begin
      act = ACT_HOLD;
      if (en_day) begin
         act = ACT_CARRY;
      end else if (up ^ down) begin
         case (sel)
            SEL_DAY: act = up ? ACT_DAY_UP : ACT_DAY_DN;
            SEL_MON: act = up ? ACT_MON_UP : ACT_MON_DN;
            default: act = ACT_HOLD;
         endcase
      end
   end

   // The single month_len lookup sees the adjusted month during a month adjust,
   // so the same-edge clamp uses the new month's length.
   always_comb begin
      mon_adj = mon;
      if (act == ACT_MON_UP)      mon_adj = (mon == MON_DEC) ? MON_JAN : bcd_inc(mon);
      else if (act == ACT_MON_DN) mon_adj = (mon == MON_JAN) ? MON_DEC : bcd_dec(mon);
   end

   month_len u_month_len (
      .mon_ten   (mon_adj[7:4]),
      .mon_unit  (mon_adj[3:0]),
      .leap_year (leap_year),
      .last_ten  (last_ten),
      .last_unit (last_unit)
   );

   assign last    = {last_ten, last_unit};
   assign at_last = (day >= last);
   assign en_yr   = ~rst & en_day & at_last & (mon == MON_DEC);

   always_comb begin
      day_n = day;
      mon_n = mon_adj;
      case (act)
         ACT_CARRY: begin
            if (at_last) begin
               day_n = DAY_FIRST;
               mon_n = (mon == MON_DEC) ? MON_JAN : bcd_inc(mon);
            end else begin
               day_n = bcd_inc(day);
            end
         end
         ACT_DAY_UP: day_n = at_last ? DAY_FIRST : bcd_inc(day);
         ACT_DAY_DN: day_n = (day <= DAY_FIRST) ? last : bcd_dec(day);
         default:    if (day > last) day_n = last;
      endcase
      {day_ten_d, day_unit_d} = day_n;
      {mon_ten_d, mon_unit_d} = mon_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         day_ten_q  <= 4'd0;
         day_unit_q <= 4'd1;
         mon_ten_q  <= 4'd0;
         mon_unit_q <= 4'd1;
      end else begin
         day_ten_q  <= day_ten_d;
         day_unit_q <= day_unit_d;
         mon_ten_q  <= mon_ten_d;
         mon_unit_q <= mon_unit_d;
      end
   end

   assign day_unit = DIG_W'(day_unit_q);
   assign day_ten  = DIG_W'(day_ten_q);
   assign mon_unit = DIG_W'(mon_unit_q);
   assign mon_ten  = DIG_W'(mon_ten_q);

endmodule

// File: tb/tb_count_date.sv
// Self-checking bench for count_date: directed calendar scenarios plus a randomized
// run compared against an integer day/month reference model.
module tb_count_date;

   logic clk = 1'b0;
   logic rst, en_day, leap_year, up, down;
   logic [1:0] sel;
   logic [3:0] day_unit, day_ten, mon_unit, mon_ten;
   logic en_yr;

   int errors = 0;
   int checks = 0;
   int md = 1;
   int mm = 1;

   count_date #(.DIG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en_day    (en_day),
      .leap_year (leap_year),
      .up        (up),
      .down      (down),
      .sel       (sel),
      .day_unit  (day_unit),
      .day_ten   (day_ten),
      .mon_unit  (mon_unit),
      .mon_ten   (mon_ten),
      .en_yr     (en_yr)
   );

   always #5 clk = ~clk;

   function automatic int last_of(input int m, input logic lp);
      case (m)
         2:             return lp ? 29 : 28;
         4, 6, 9, 11:   return 30;
         default:       return 31;
      endcase
   endfunction

   function automatic logic [15:0] bcd_date(input int d, input int m);
      return {4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   function automatic logic exp_yr();
      return !rst && en_day && (md >= last_of(mm, leap_year)) && (mm == 12);
   endfunction

   function automatic logic [15:0] dut_date();
      return {day_ten, day_unit, mon_ten, mon_unit};
   endfunction

   // Advance the calendar model with the inputs the DUT sees at this edge.
   task automatic tick();
      int lim;
      lim = last_of(mm, leap_year);
      if (rst) begin
         md = 1; mm = 1;
      end else if (en_day) begin
         if (md >= lim) begin
            md = 1;
            mm = (mm == 12) ? 1 : mm + 1;
         end else md = md + 1;
      end else if ((up ^ down) && sel == 2'b01) begin
         if (up) md = (md >= lim) ? 1 : md + 1;
         else    md = (md <= 1) ? lim : md - 1;
      end else if ((up ^ down) && sel == 2'b10) begin
         if (up) mm = (mm == 12) ? 1 : mm + 1;
         else    mm = (mm == 1) ? 12 : mm - 1;
         if (md > last_of(mm, leap_year)) md = last_of(mm, leap_year);
      end else if (md > lim) begin
         md = lim;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic u, input logic dn, input logic [1:0] s);
      en_day = e; up = u; down = dn; sel = s;
   endtask

   task automatic goto_date(input int d, input int m);
      rst = 1'b1; drive(0, 0, 0, 2'b00); tick();
      rst = 1'b0; leap_year = 1'b1;
      for (int i = 1; i < m; i++) begin drive(0, 1, 0, 2'b10); tick(); end
      for (int i = 1; i < d; i++) begin drive(0, 1, 0, 2'b01); tick(); end
      drive(0, 0, 0, 2'b00);
   endtask

   task automatic test_reset();
      rst = 1'b1; leap_year = 1'b0; drive(1, 0, 0, 2'b00);
      #1;
      checks++;
      if (en_yr !== 1'b0) begin errors++; $display("FAIL reset_en_yr got=%b want=0", en_yr); end
      tick();
      checks++;
      if (dut_date() !== 16'h0101) begin errors++; $display("FAIL reset_date got=%h want=0101", dut_date()); end
      rst = 1'b0; drive(0, 0, 0, 2'b00);
   endtask

   task automatic test_day_roll();
      int yr_seen;
      yr_seen = 0;
      leap_year = 1'b0;
      for (int i = 0; i < 30; i++) begin
         drive(1, 0, 0, 2'b00); #1;
         if (en_yr !== 1'b0) yr_seen++;
         tick();
      end
      checks++;
      if (dut_date() !== 16'h3101) begin errors++; $display("FAIL roll_31jan got=%h want=3101", dut_date()); end
      drive(1, 0, 0, 2'b00); #1;
      if (en_yr !== 1'b0) yr_seen++;
      tick();
      checks++;
      if (dut_date() !== 16'h0102) begin errors++; $display("FAIL roll_01feb got=%h want=0102", dut_date()); end
      checks++;
      if (yr_seen != 0) begin errors++; $display("FAIL roll_en_yr got=%0d highs want=0", yr_seen); end
      drive(0, 0, 0, 2'b00);
   endtask

   task automatic test_feb(input logic lp);
      goto_date(28, 2);
      leap_year = lp;
      drive(1, 0, 0, 2'b00); tick();
      if (lp) begin
         checks++;
         if (dut_date() !== 16'h2902) begin errors++; $display("FAIL feb_leap_29 got=%h want=2902", dut_date()); end
         tick();
      end
      checks++;
      if (dut_date() !== 16'h0103) begin errors++; $display("FAIL feb_to_mar leap=%b got=%h want=0103", lp, dut_date()); end
      drive(0, 0, 0, 2'b00);
   endtask

   task automatic test_year_wrap();
      goto_date(31, 12);
      leap_year = 1'b0;
      drive(1, 0, 0, 2'b00); #1;
      checks++;
      if (en_yr !== 1'b1) begin errors++; $display("FAIL year_en_yr got=%b want=1", en_yr); end
      tick();
      checks++;
      if (dut_date() !== 16'h0101) begin errors++; $display("FAIL year_wrap got=%h want=0101", dut_date()); end
      drive(0, 0, 0, 2'b00); #1;
      checks++;
      if (en_yr !== 1'b0) begin errors++; $display("FAIL year_en_yr_after got=%b want=0", en_yr); end
   endtask

   task automatic test_month_adjust();
      goto_date(31, 1);
      leap_year = 1'b0;
      drive(0, 1, 0, 2'b10); #1;
      checks++;
      if (en_yr !== 1'b0) begin errors++; $display("FAIL madj_en_yr got=%b want=0", en_yr); end
      tick();
      checks++;
      if (dut_date() !== 16'h2802) begin errors++; $display("FAIL madj_clamp got=%h want=2802", dut_date()); end
      goto_date(1, 3);
      drive(0, 0, 1, 2'b10); tick();
      checks++;
      if (dut_date() !== 16'h0102) begin errors++; $display("FAIL madj_down got=%h want=0102", dut_date()); end
      goto_date(1, 1);
      drive(0, 0, 1, 2'b10); tick();
      checks++;
      if (dut_date() !== 16'h0112) begin errors++; $display("FAIL madj_wrap_dn got=%h want=0112", dut_date()); end
      drive(0, 0, 0, 2'b00);
   endtask

   task automatic test_leap_drop();
      goto_date(29, 2);
      leap_year = 1'b0;
      tick();
      checks++;
      if (dut_date() !== 16'h2802) begin errors++; $display("FAIL leap_drop got=%h want=2802", dut_date()); end
   endtask

   task automatic test_day_down();
      goto_date(1, 5);
      drive(0, 0, 1, 2'b01); tick();
      checks++;
      if (dut_date() !== 16'h3105) begin errors++; $display("FAIL dadj_may got=%h want=3105", dut_date()); end
      goto_date(1, 4);
      drive(0, 0, 1, 2'b01); tick();
      checks++;
      if (dut_date() !== 16'h3004) begin errors++; $display("FAIL dadj_apr got=%h want=3004", dut_date()); end
      drive(0, 1, 0, 2'b01); tick();
      checks++;
      if (dut_date() !== 16'h0104) begin errors++; $display("FAIL dadj_up_wrap got=%h want=0104", dut_date()); end
      drive(0, 0, 0, 2'b00);
   endtask

   task automatic test_hold();
      goto_date(15, 6);
      drive(0, 1, 1, 2'b01); tick();
      drive(0, 1, 0, 2'b11); tick();
      drive(0, 0, 1, 2'b00); tick();
      drive(0, 1, 1, 2'b10); tick();
      checks++;
      if (dut_date() !== 16'h1506) begin errors++; $display("FAIL hold got=%h want=1506", dut_date()); end
      drive(0, 0, 0, 2'b00);
   endtask

   task automatic test_priority();
      goto_date(31, 1);
      leap_year = 1'b0;
      drive(1, 1, 0, 2'b01); tick();
      checks++;
      if (dut_date() !== 16'h0102) begin errors++; $display("FAIL prio_en_day got=%h want=0102", dut_date()); end
      drive(0, 0, 0, 2'b00);
   endtask

   task automatic test_reset_mid();
      goto_date(31, 12);
      rst = 1'b1; drive(1, 0, 0, 2'b00); #1;
      checks++;
      if (en_yr !== 1'b0) begin errors++; $display("FAIL rst_mid_en_yr got=%b want=0", en_yr); end
      tick();
      checks++;
      if (dut_date() !== 16'h0101) begin errors++; $display("FAIL rst_mid got=%h want=0101", dut_date()); end
      rst = 1'b0; drive(0, 0, 0, 2'b00);
   endtask

   task automatic test_random();
      int bad_date, bad_yr;
      bad_date = 0; bad_yr = 0;
      rst = 1'b1; drive(0, 0, 0, 2'b00); tick(); rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) leap_year = ~leap_year;
         drive(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 2'($urandom));
         #1;
         checks++;
         if (en_yr !== exp_yr()) begin
            errors++;
            if (bad_yr++ < 5) $display("FAIL rand_en_yr cyc=%0d got=%b want=%b", i, en_yr, exp_yr());
         end
         tick();
         checks++;
         if (dut_date() !== bcd_date(md, mm)) begin
            errors++;
            if (bad_date++ < 5) $display("FAIL rand_date cyc=%0d got=%h want=%h", i, dut_date(), bcd_date(md, mm));
         end
      end
      rst = 1'b0; drive(0, 0, 0, 2'b00);
   endtask

   initial begin
      rst = 1'b1; leap_year = 1'b0;
      drive(0, 0, 0, 2'b00);
      @(posedge clk); #1;
      test_reset();
      test_day_roll();
      test_feb(1'b1);
      test_feb(1'b0);
      test_year_wrap();
      test_month_adjust();
      test_leap_drop();
      test_day_down();
      test_hold();
      test_priority();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
